// File: rtl/otter_mcycle_fsm.sv
// rtl/otter_mcycle_fsm.sv - multi-cycle OTTER control FSM with trap entry
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   opcode     IR[6:0], valid from DECODE until the next FETCH
//   funct3     IR[14:12], same validity as opcode
//   intr       level interrupt request, sampled in an instruction's final cycle
//   mem_rdy    memory handshake, 1 = current read/write completes this cycle
//   mem_rden1  instruction-fetch read strobe
//   mem_rden2  data read strobe
//   mem_we2    data write strobe
//   pc_we      PC update strobe
//   rf_we      register-file write strobe
//   csr_we     CSR write strobe
//   int_taken  trap-entry pulse
//   illegal    trap cause, 1 = illegal opcode, 0 = interrupt
//   imm_sel    immediate select (0 I, 1 S, 2 B, 3 U, 4 J)
//   state      current state code for debug
module otter_mcycle_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       intr,
    input  logic       mem_rdy,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       pc_we,
    output logic       rf_we,
    output logic       csr_we,
    output logic       int_taken,
    output logic       illegal,
    output logic [2:0] imm_sel,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_WB       = 3'd4,
        S_TRAP     = 3'd5
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t     cur_state;
    state_t     nxt_state;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       ill_q;
    logic       ill_d;
    logic       final_cycle;
    logic       op_legal;

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            op_q      <= 7'd0;
            f3_q      <= 3'd0;
            ill_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ill_q     <= ill_d;
            // Later states only ever look at the captured copy of the IR fields.
            if (cur_state == S_DECODE) begin
                op_q <= opcode;
                f3_q <= funct3;
            end
        end
    end

    always_comb begin
        nxt_state   = S_FETCH;
        ill_d       = ill_q;
        final_cycle = 1'b0;
        mem_rden1   = 1'b0;
        mem_rden2   = 1'b0;
        mem_we2     = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        csr_we      = 1'b0;
        int_taken   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_rden1 = 1'b1;
                nxt_state = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (op_legal) begin
                    nxt_state = S_EXEC;
                end else begin
                    nxt_state = S_TRAP;
                    ill_d     = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_q == OP_LOAD) begin
                    mem_rden2 = 1'b1;
                    nxt_state = S_MEM_WAIT;
                end else if (op_q == OP_STORE) begin
                    mem_we2 = 1'b1;
                    if (mem_rdy) begin
                        pc_we       = 1'b1;
                        final_cycle = 1'b1;
                    end else begin
                        nxt_state = S_EXEC;
                    end
                end else begin
                    pc_we       = 1'b1;
                    final_cycle = 1'b1;
                    // ECALL/EBREAK class (SYSTEM, funct3=0) writes neither RF nor CSR.
                    rf_we  = !((op_q == OP_BRANCH) ||
                               ((op_q == OP_SYSTEM) && (f3_q == 3'b000)));
                    csr_we = (op_q == OP_SYSTEM) && (f3_q != 3'b000);
                end
            end
            S_MEM_WAIT: begin
                mem_rden2 = 1'b1;
                nxt_state = mem_rdy ? S_WB : S_MEM_WAIT;
            end
            S_WB: begin
                rf_we       = 1'b1;
                pc_we       = 1'b1;
                final_cycle = 1'b1;
            end
            S_TRAP: begin
                // intr is deliberately not examined here: no nested trap entry.
                int_taken = 1'b1;
                pc_we     = 1'b1;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase

        if (final_cycle) begin
            if (intr) begin
                nxt_state = S_TRAP;
                ill_d     = 1'b0;
            end else begin
                nxt_state = S_FETCH;
            end
        end
    end

    always_comb begin
        case (op_q)
            OP_STORE:         imm_sel = 3'd1;
            OP_BRANCH:        imm_sel = 3'd2;
            OP_LUI, OP_AUIPC: imm_sel = 3'd3;
            OP_JAL:           imm_sel = 3'd4;
            default:          imm_sel = 3'd0;
        endcase
    end

    assign illegal = ill_q;
    assign state   = cur_state;

endmodule

// File: tb/tb_otter_mcycle_fsm.sv
// tb/tb_otter_mcycle_fsm.sv - scoreboard bench for otter_mcycle_fsm
module tb_otter_mcycle_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       intr;
    logic       mem_rdy;
    logic       mem_rden1, mem_rden2, mem_we2, pc_we, rf_we, csr_we, int_taken, illegal;
    logic [2:0] imm_sel;
    logic [2:0] state;

    otter_mcycle_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct3    (funct3),
        .intr      (intr),
        .mem_rdy   (mem_rdy),
        .mem_rden1 (mem_rden1),
        .mem_rden2 (mem_rden2),
        .mem_we2   (mem_we2),
        .pc_we     (pc_we),
        .rf_we     (rf_we),
        .csr_we    (csr_we),
        .int_taken (int_taken),
        .illegal   (illegal),
        .imm_sel   (imm_sel),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [13:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [6:0] cap_op;
    logic       cap_ill;

    // Strobe bits {rden1, rden2, we2, pc, rf, csr, int_taken}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_RD1   = 7'b1000000;
    localparam logic [6:0] S_RD2   = 7'b0100000;
    localparam logic [6:0] S_WE2   = 7'b0010000;
    localparam logic [6:0] S_WE2PC = 7'b0011000;
    localparam logic [6:0] S_PC    = 7'b0001000;
    localparam logic [6:0] S_PCRF  = 7'b0001100;
    localparam logic [6:0] S_CSR   = 7'b0001110;
    localparam logic [6:0] S_TRAP  = 7'b0001001;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic logic [13:0] actual_vec();
        return {state, imm_sel, mem_rden1, mem_rden2, mem_we2, pc_we, rf_we,
                csr_we, int_taken, illegal};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d imm=%0d str=%b ill=%b, want st=%0d imm=%0d str=%b ill=%b",
                     name, act[13:11], act[10:8], act[7:1], act[0],
                     exp[13:11], exp[10:8], exp[7:1], exp[0]);
        end
    endtask

    // Monitor: one expectation per cycle, compared at the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, actual_vec(), e.val);
        end
    end

    // Drive one cycle's inputs and queue what the DUT must show in that cycle.
    task automatic cyc(input string name, input logic rdy, input logic irq,
                       input logic [2:0] st, input logic [6:0] str);
        exp_t e;
        mem_rdy = rdy;
        intr    = irq;
        e.name  = name;
        e.val   = {st, imm_of(cap_op), str, cap_ill};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
    endtask

    initial begin
        rst_n   = 1'b0;
        opcode  = 7'd0;
        funct3  = 3'd0;
        intr    = 1'b0;
        mem_rdy = 1'b0;
        cap_op  = 7'd0;
        cap_ill = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds FETCH regardless of mem_rdy/intr.
        set_ir(7'b1111111, 3'd0);
        cyc("reset_a", 1'b1, 1'b1, 3'd0, S_RD1);
        cyc("reset_b", 1'b1, 1'b1, 3'd0, S_RD1);

        // ADD
        rst_n = 1'b1;
        set_ir(7'b0110011, 3'd0);
        cyc("add_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("add_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0110011;
        cyc("add_exec",  1'b1, 1'b0, 3'd2, S_PCRF);

        // LW with two wait cycles
        set_ir(7'b0000011, 3'd2);
        cyc("lw_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("lw_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0000011;
        cyc("lw_exec",  1'b0, 1'b0, 3'd2, S_RD2);
        cyc("lw_mw0",   1'b0, 1'b0, 3'd3, S_RD2);
        cyc("lw_mw1",   1'b0, 1'b0, 3'd3, S_RD2);
        cyc("lw_mw2",   1'b1, 1'b0, 3'd3, S_RD2);
        cyc("lw_wb",    1'b1, 1'b0, 3'd4, S_PCRF);

        // SW with one stall in EXEC
        set_ir(7'b0100011, 3'd2);
        cyc("sw_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("sw_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0100011;
        cyc("sw_exec0", 1'b0, 1'b0, 3'd2, S_WE2);
        cyc("sw_exec1", 1'b1, 1'b0, 3'd2, S_WE2PC);

        // LUI with a slow fetch
        set_ir(7'b0110111, 3'd0);
        cyc("lui_fwait0", 1'b0, 1'b0, 3'd0, S_RD1);
        cyc("lui_fwait1", 1'b0, 1'b0, 3'd0, S_RD1);
        cyc("lui_fetch",  1'b1, 1'b0, 3'd0, S_RD1);
        cyc("lui_dec",    1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0110111;
        cyc("lui_exec",   1'b1, 1'b0, 3'd2, S_PCRF);

        // JAL
        set_ir(7'b1101111, 3'd0);
        cyc("jal_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("jal_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b1101111;
        cyc("jal_exec",  1'b1, 1'b0, 3'd2, S_PCRF);

        // CSRRW: funct3 changes after DECODE must not matter
        set_ir(7'b1110011, 3'b001);
        cyc("csr_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("csr_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b1110011;
        set_ir(7'b1100011, 3'b000);
        cyc("csr_exec",  1'b1, 1'b0, 3'd2, S_CSR);

        // ECALL: no RF or CSR write
        set_ir(7'b1110011, 3'b000);
        cyc("ecall_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("ecall_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cyc("ecall_exec",  1'b1, 1'b0, 3'd2, S_PC);

        // Illegal opcode traps; the cause flag persists afterwards
        set_ir(7'b1111111, 3'd0);
        cyc("ill_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("ill_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op  = 7'b1111111;
        cap_ill = 1'b1;
        cyc("ill_trap",  1'b1, 1'b1, 3'd5, S_TRAP);

        // ADDI after the trap
        set_ir(7'b0010011, 3'd0);
        cyc("addi_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("addi_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0010011;
        cyc("addi_exec",  1'b1, 1'b0, 3'd2, S_PCRF);

        // BRANCH with interrupt in the final cycle; intr still high in TRAP
        set_ir(7'b1100011, 3'd0);
        cyc("br_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("br_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b1100011;
        cyc("br_exec",  1'b1, 1'b1, 3'd2, S_PC);
        cap_ill = 1'b0;
        cyc("br_trap",  1'b1, 1'b1, 3'd5, S_TRAP);
        cyc("br_after", 1'b0, 1'b1, 3'd0, S_RD1);

        // LW aborted by reset while in MEM_WAIT
        set_ir(7'b0000011, 3'd2);
        cyc("rlw_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("rlw_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0000011;
        cyc("rlw_exec",  1'b0, 1'b0, 3'd2, S_RD2);
        mem_rdy = 1'b0;
        #6;
        rst_n = 1'b0;
        #1;
        cap_op  = 7'd0;
        cap_ill = 1'b0;
        check("async_reset", actual_vec(), {3'd0, 3'd0, S_RD1, 1'b0});
        @(posedge clk);
        #1;
        cyc("rlw_rst",   1'b1, 1'b0, 3'd0, S_RD1);
        rst_n = 1'b1;
        set_ir(7'b0110011, 3'd0);
        cyc("post_fetch", 1'b1, 1'b0, 3'd0, S_RD1);
        cyc("post_dec",   1'b1, 1'b0, 3'd1, S_NONE);
        cap_op = 7'b0110011;
        cyc("post_exec",  1'b1, 1'b0, 3'd2, S_PCRF);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_mcycle_fsm.md
OTTER_MCYCLE_FSM -- requirements
Module: otter_mcycle_fsm

Interface
REQ-001 The block SHALL have these parameters, each listed as name, default, meaning: none; all encodings are fixed by this document.
REQ-002 CLK  in  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 RST_N  in  1  reset, asynchronous and active-low.
REQ-004 OPCODE  in  7  IR[6:0]; valid from the DECODE cycle until the next FETCH.
REQ-005 FUNCT3  in  3  IR[14:12]; same validity as OPCODE.
REQ-006 INTR  in  1  level interrupt request.
REQ-007 MEM_RDY  in  1  memory handshake; 1 = the current read or write completes this cycle.
REQ-008 MEM_RDEN1  out  1  instruction-fetch read strobe.
REQ-009 MEM_RDEN2  out  1  data read strobe.
REQ-010 MEM_WE2  out  1  data write strobe.
REQ-011 PC_WE  out  1  PC update strobe.
REQ-012 RF_WE  out  1  register-file write strobe.
REQ-013 CSR_WE  out  1  CSR write strobe.
REQ-014 INT_TAKEN  out  1  trap-entry pulse.
REQ-015 ILLEGAL  out  1  trap cause; 1 = illegal opcode, 0 = interrupt.
REQ-016 IMM_SEL  out  3  immediate select: 0 I, 1 S, 2 B, 3 U, 4 J.
REQ-017 STATE  out  3  current state code, for debug.

Function
REQ-018 State codes SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM_WAIT=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-019 In FETCH, MEM_RDEN1 SHALL be 1; the FSM SHALL stay in FETCH while MEM_RDY=0 and go to DECODE when MEM_RDY=1.
REQ-020 In DECODE, OPCODE and FUNCT3 SHALL be captured into internal registers at the clock edge; all later states SHALL use only the captured values.
REQ-021 Legal opcodes SHALL be: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011.
REQ-022 In DECODE, a legal opcode SHALL go to EXEC; any other opcode SHALL go to TRAP with the ILLEGAL flag registered as 1, and no PC_WE or RF_WE SHALL be asserted for that instruction.
REQ-023 EXEC with LOAD (0000011): MEM_RDEN2=1, next state MEM_WAIT.
REQ-024 MEM_WAIT: MEM_RDEN2=1; the FSM SHALL hold while MEM_RDY=0 and go to WB when MEM_RDY=1.
REQ-025 WB: RF_WE=1 and PC_WE=1; this SHALL be the final cycle of a load.
REQ-026 EXEC with STORE (0100011): MEM_WE2=1 and the FSM SHALL hold in EXEC while MEM_RDY=0; PC_WE=1 only in the cycle where MEM_RDY=1, which SHALL be the final cycle.
REQ-027 EXEC with any other legal opcode: PC_WE=1 and this SHALL be the final cycle.
REQ-028 In that final EXEC cycle, RF_WE SHALL be 1 except for BRANCH, and except for SYSTEM with FUNCT3=000.
REQ-029 CSR_WE SHALL be 1 for SYSTEM with FUNCT3 not equal to 000.
REQ-030 Final-cycle exit: INTR=1, sampled in the final cycle, SHALL give next state TRAP with ILLEGAL registered as 0; otherwise the next state SHALL be FETCH.
REQ-031 TRAP SHALL last exactly one cycle with INT_TAKEN=1, PC_WE=1 and ILLEGAL held; next state FETCH. INTR SHALL be ignored in TRAP, so no nested trap occurs.
REQ-032 IMM_SEL SHALL decode the captured opcode as follows:
- S for STORE
- B for BRANCH
- U for LUI and AUIPC
- J for JAL
- I otherwise
REQ-033 The strobes SHALL be combinational decodes of state, captured registers, INTR and MEM_RDY. At most one of MEM_RDEN1, MEM_RDEN2 and MEM_WE2 SHALL be 1 in any cycle.
REQ-034 Minimum instruction latency with MEM_RDY held at 1 SHALL be:
- 3 cycles for ALU, branch, jump and system instructions
- 3 cycles for stores
- 5 cycles for loads

Reset
REQ-035 RST_N=0 SHALL immediately, without waiting for a clock edge, force STATE=FETCH and clear the captured opcode, captured FUNCT3 and the ILLEGAL flag to 0.
REQ-036 During reset, all strobes except MEM_RDEN1 SHALL be 0, and IMM_SEL SHALL be 0.
REQ-037 Reset asserted mid-instruction, including in MEM_WAIT or TRAP, SHALL abort the instruction with no further PC_WE, RF_WE, CSR_WE or MEM_WE2.
REQ-038 The first FETCH after RST_N rises SHALL begin on the next clock edge.

Verification
REQ-039 Scenario, ADD: OPCODE=0110011 with MEM_RDY=1 -> STATE sequence 0,1,2,0; RF_WE=1 and PC_WE=1 only in the EXEC cycle; IMM_SEL=0.
REQ-040 Scenario, LW: OPCODE=0000011 with MEM_RDY low for 2 cycles in MEM_WAIT -> STATE sequence 0,1,2,3,3,3,4,0; RF_WE=1 only in WB.
REQ-041 Scenario, SW: OPCODE=0100011 with MEM_RDY=0 for 1 EXEC cycle -> EXEC lasts 2 cycles; MEM_WE2=1 in both; PC_WE=1 only in the second; IMM_SEL=1.
REQ-042 Scenario, illegal: OPCODE=1111111 -> STATE sequence 0,1,5,0; INT_TAKEN=1 and ILLEGAL=1 in TRAP; RF_WE never asserted.
REQ-043 Scenario, interrupt: INTR=1 during the final EXEC cycle of a BRANCH -> next STATE=5; ILLEGAL=0; RF_WE=0 throughout.
REQ-044 Scenario, reset: RST_N pulsed low while STATE=3 -> STATE=0 before the next clock edge; no RF_WE follows.
